// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch direction predictor: mode codes,
// the 2-bit saturating counter type and its step functions.
package bpu_pkg;

    localparam logic [1:0] MODE_LOCAL  = 2'd0;
    localparam logic [1:0] MODE_GSHARE = 2'd1;
    localparam logic [1:0] MODE_TOURN  = 2'd2;

    typedef logic [1:0] ctr_t;

    // Weakly not-taken for direction tables, weakly local for the chooser.
    localparam ctr_t CTR_WNT = 2'b01;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch lookup, Memory-stage training, flush and statistics signals between
// the pipeline datapath (master) and the predictor (slave).
interface bpu_if;
    logic [31:0] pcF;
    logic        pbranchF;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_pred;
    logic        pmis;
    logic        flushD;
    logic        flushE;
    logic        flushM;
    logic        clr_stats;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;

    modport master (
        output pcF, update_en, update_pc, update_taken, update_pred, clr_stats,
        input  pbranchF, pmis, flushD, flushE, flushM, br_cnt, mis_cnt
    );

    modport slave (
        input  pcF, update_en, update_pc, update_taken, update_pred, clr_stats,
        output pbranchF, pmis, flushD, flushE, flushM, br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_predict_unit_pht_bank.sv
// Table of 2-bit saturating counters: combinational lookup port plus a train
// port that also exposes the pre-edge value of the entry it is training.
module pht_bank
    import bpu_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_t             rd_ctr,
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    input  logic             taken,
    output ctr_t             trn_ctr
);

    ctr_t mem_reg [2**IDX_W];

    assign rd_ctr  = mem_reg[rd_idx];
    assign trn_ctr = mem_reg[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                mem_reg[i] <= CTR_WNT;
            end
        end else if (en) begin
            mem_reg[idx] <= taken ? sat_inc(trn_ctr) : sat_dec(trn_ctr);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Local / gshare / tournament branch direction predictor: Fetch-stage lookup,
// Memory-stage training, mispredict flush requests and saturating statistics.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int MODE      = 2,
    parameter int PHT_IDX_W = 10,
    parameter int BHT_IDX_W = 8,
    parameter int LHR_W     = 8,
    parameter int GHR_W     = 10
) (
    input  logic clk,
    input  logic rst,
    bpu_if.slave bus
);

    localparam logic [1:0] MODE_SEL = MODE[1:0];

    logic [LHR_W-1:0]     bht_reg [2**BHT_IDX_W];
    logic [GHR_W-1:0]     ghr_reg;
    logic [31:0]          br_cnt_reg;
    logic [31:0]          mis_cnt_reg;

    logic [BHT_IDX_W-1:0] f_bht_idx, u_bht_idx;
    logic [LHR_W-1:0]     f_lhr, u_lhr;
    logic [PHT_IDX_W-1:0] f_cidx, u_cidx, f_gidx, u_gidx;
    ctr_t                 lpht_f, gpht_f, ch_f, lpht_u, gpht_u, ch_trn_unused;
    logic                 loc_ok, gsh_ok, ch_en;
    logic                 unused_bits;

    // Lookup indices come from the fetch PC, training indices from the
    // resolving PC; both use the current (pre-edge) histories.
    assign f_bht_idx = bus.pcF[BHT_IDX_W+1:2];
    assign u_bht_idx = bus.update_pc[BHT_IDX_W+1:2];
    assign f_lhr     = bht_reg[f_bht_idx];
    assign u_lhr     = bht_reg[u_bht_idx];
    assign f_cidx    = bus.pcF[PHT_IDX_W+1:2];
    assign u_cidx    = bus.update_pc[PHT_IDX_W+1:2];
    assign f_gidx    = f_cidx ^ PHT_IDX_W'(ghr_reg);
    assign u_gidx    = u_cidx ^ PHT_IDX_W'(ghr_reg);

    assign loc_ok = (lpht_u[1] == bus.update_taken);
    assign gsh_ok = (gpht_u[1] == bus.update_taken);
    assign ch_en  = bus.update_en & (loc_ok ^ gsh_ok);

    pht_bank #(.IDX_W(LHR_W)) u_local (
        .clk(clk), .rst(rst),
        .rd_idx(f_lhr), .rd_ctr(lpht_f),
        .en(bus.update_en), .idx(u_lhr), .taken(bus.update_taken), .trn_ctr(lpht_u)
    );

    pht_bank #(.IDX_W(PHT_IDX_W)) u_global (
        .clk(clk), .rst(rst),
        .rd_idx(f_gidx), .rd_ctr(gpht_f),
        .en(bus.update_en), .idx(u_gidx), .taken(bus.update_taken), .trn_ctr(gpht_u)
    );

    // Chooser "taken" means gshare was the correct component.
    pht_bank #(.IDX_W(PHT_IDX_W)) u_chooser (
        .clk(clk), .rst(rst),
        .rd_idx(f_cidx), .rd_ctr(ch_f),
        .en(ch_en), .idx(u_cidx), .taken(gsh_ok), .trn_ctr(ch_trn_unused)
    );

    always_comb begin
        bus.pbranchF = ch_f[1] ? gpht_f[1] : lpht_f[1];
        case (MODE_SEL)
            MODE_LOCAL:  bus.pbranchF = lpht_f[1];
            MODE_GSHARE: bus.pbranchF = gpht_f[1];
            default:     bus.pbranchF = ch_f[1] ? gpht_f[1] : lpht_f[1];
        endcase
    end

    assign bus.pmis   = bus.update_en & (bus.update_taken ^ bus.update_pred);
    assign bus.flushD = bus.pmis;
    assign bus.flushE = bus.pmis;
    assign bus.flushM = bus.pmis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**BHT_IDX_W; i++) begin
                bht_reg[i] <= '0;
            end
            ghr_reg <= '0;
        end else if (bus.update_en) begin
            bht_reg[u_bht_idx] <= {u_lhr[LHR_W-2:0], bus.update_taken};
            ghr_reg            <= {ghr_reg[GHR_W-2:0], bus.update_taken};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_reg  <= '0;
            mis_cnt_reg <= '0;
        end else if (bus.clr_stats) begin
            br_cnt_reg  <= '0;
            mis_cnt_reg <= '0;
        end else begin
            if (bus.update_en && (br_cnt_reg != 32'hFFFF_FFFF)) begin
                br_cnt_reg <= br_cnt_reg + 32'd1;
            end
            if (bus.pmis && (mis_cnt_reg != 32'hFFFF_FFFF)) begin
                mis_cnt_reg <= mis_cnt_reg + 32'd1;
            end
        end
    end

    assign bus.br_cnt  = br_cnt_reg;
    assign bus.mis_cnt = mis_cnt_reg;

    // Only the index/predict bits of the PCs and counters are consumed.
    assign unused_bits = ^{bus.pcF, bus.update_pc, lpht_f[0], gpht_f[0], ch_f[0],
                           lpht_u[0], gpht_u[0]};

endmodule
